// File: rtl/vga_scanout_ctrl.sv
// vga_scanout_ctrl: VGA timing, framebuffer address generation, palette lookup and aligned sync outputs
// Ports:
//   iVGA_CLK             pixel clock; iRST synchronous active-high reset
//   oFB_ADDR, iFB_INDEX  framebuffer read address / returned palette index (memory has 1-cycle latency)
//   iPAL_WE, iPAL_ADDR, iPAL_DATA  palette write port, data packed {b,g,r}
//   oHS, oVS             active-low syncs; oBLANK_n high during visible pixels
//   b_data, g_data, r_data  colour, 0 outside visible area
//   oFRAME_START         one-cycle pulse on the first visible pixel of a frame
// Optional VGA_CURSOR_EN adds iCUR_X/iCUR_Y and a CUR_SIZE square cursor drawn in CUR_COLOR.
module vga_scanout_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 0,
    parameter int ADDR_W      = 19,
    parameter int IDX_W       = 8,
    parameter int COL_W       = 8
`ifdef VGA_CURSOR_EN
    ,
    parameter int CUR_SIZE          = 8,
    parameter logic [23:0] CUR_COLOR = 24'hFFFFFF
`endif
) (
    input  logic               iVGA_CLK,
    input  logic               iRST,
    output logic [ADDR_W-1:0]  oFB_ADDR,
    input  logic [IDX_W-1:0]   iFB_INDEX,
    input  logic               iPAL_WE,
    input  logic [IDX_W-1:0]   iPAL_ADDR,
    input  logic [3*COL_W-1:0] iPAL_DATA,
`ifdef VGA_CURSOR_EN
    input  logic [10:0]        iCUR_X,
    input  logic [9:0]         iCUR_Y,
`endif
    output logic               oHS,
    output logic               oVS,
    output logic               oBLANK_n,
    output logic [COL_W-1:0]   b_data,
    output logic [COL_W-1:0]   g_data,
    output logic [COL_W-1:0]   r_data,
    output logic               oFRAME_START
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int FB_W = H_ACTIVE >> SCALE_SHIFT;
    localparam int DW = 3 * COL_W;
    // low v_cnt bits that must all be ones before the framebuffer row advances
    localparam logic [VW-1:0] V_MASK = VW'((1 << SCALE_SHIFT) - 1);

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [ADDR_W-1:0] row_base;
    logic              h_end, v_end, active, hs, vs, fs;
    // bit i holds the stage i+1 copy; bit 2 drives the outputs
    logic [2:0]        hs_d, vs_d, blank_d, fs_d;
    logic [DW-1:0]     pal [2**IDX_W];
    logic [DW-1:0]     col;

    assign h_end  = h_cnt == HW'(H_TOTAL - 1);
    assign v_end  = v_cnt == VW'(V_TOTAL - 1);
    assign active = h_cnt < HW'(H_ACTIVE) && v_cnt < VW'(V_ACTIVE);
    assign hs     = !(h_cnt >= HW'(H_ACTIVE + H_FP) && h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs     = !(v_cnt >= VW'(V_ACTIVE + V_FP) && v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    assign fs     = h_cnt == '0 && v_cnt == '0;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            row_base <= '0;
            oFB_ADDR <= '0;
        end else begin
            h_cnt <= h_end ? '0 : h_cnt + 1'b1;
            if (h_end) begin
                v_cnt    <= v_end ? '0 : v_cnt + 1'b1;
                row_base <= v_end ? '0 : (v_cnt & V_MASK) == V_MASK ? row_base + ADDR_W'(FB_W) : row_base;
            end
            if (active)
                oFB_ADDR <= row_base + ADDR_W'(h_cnt >> SCALE_SHIFT);
        end
    end

`ifdef VGA_CURSOR_EN
    localparam logic [DW-1:0] CUR = DW'(CUR_COLOR);
    logic [10:0] cur_x;
    logic [9:0]  cur_y;
    logic        hit;
    logic [1:0]  hit_d;

    // position is latched once per frame so a moving cursor never tears
    assign hit = active && 16'(h_cnt) >= 16'(cur_x) && 16'(h_cnt) < 16'(cur_x) + 16'(CUR_SIZE)
                        && 16'(v_cnt) >= 16'(cur_y) && 16'(v_cnt) < 16'(cur_y) + 16'(CUR_SIZE);

    always_ff @(posedge iVGA_CLK) begin
        if (iRST || (h_end && v_end)) begin
            cur_x <= iCUR_X;
            cur_y <= iCUR_Y;
        end
        hit_d <= iRST ? 2'b00 : {hit_d[0], hit};
    end
`endif

    // palette RAM: a read on the same edge as a write to that entry returns the old value
    always_ff @(posedge iVGA_CLK)
        if (iPAL_WE && !iRST)
            pal[iPAL_ADDR] <= iPAL_DATA;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            hs_d    <= '1;
            vs_d    <= '1;
            blank_d <= '0;
            fs_d    <= '0;
            col     <= '0;
        end else begin
            hs_d    <= {hs_d[1:0], hs};
            vs_d    <= {vs_d[1:0], vs};
            blank_d <= {blank_d[1:0], active};
            fs_d    <= {fs_d[1:0], fs};
`ifdef VGA_CURSOR_EN
            col     <= !blank_d[1] ? '0 : hit_d[1] ? CUR : pal[iFB_INDEX];
`else
            col     <= !blank_d[1] ? '0 : pal[iFB_INDEX];
`endif
        end
    end

    assign oHS          = hs_d[2];
    assign oVS          = vs_d[2];
    assign oBLANK_n     = blank_d[2];
    assign oFRAME_START = fs_d[2];
    assign {b_data, g_data, r_data} = col;
endmodule

// File: tb/tb_vga_scanout_ctrl.sv
// tb_vga_scanout_ctrl: scoreboard bench for vga_scanout_ctrl on a reduced 24x12 timing with 2x scaling
module tb_vga_scanout_ctrl;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8, VF = 1, VS = 2, VB = 1;
    localparam int SS = 1, AW = 10;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct {
        logic       hs;
        logic       vs;
        logic       act;
        logic       fs;
        logic [7:0] idx;
    } exp_t;

    typedef struct {
        int v;
        int h;
        int addr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pal_we = 1'b0;
    logic [7:0]    pal_addr = '0;
    logic [23:0]   pal_data = '0;
    logic [7:0]    fb_index = '0;
    logic [AW-1:0] fb_addr;
    logic          hs, vs, blank_n, frame_start;
    logic [7:0]    b, g, r;
    logic          fb_all5 = 1'b0;

    int checks = 0, errors = 0;
    int cyc = 0, rel_cyc = 0;
    int m_h = 0, m_v = 0, prev_h = 0, prev_v = 0;
    int cnt_len = 0, cnt_blank = 0, cnt_hs = 0, cnt_vs = 0;
    bit armed = 0, win = 0, rel_pending = 0, last_rst = 1, prev_act = 0;
    bit pw_en = 0;
    logic [7:0]    pw_a;
    logic [23:0]   pw_d;
    logic [AW-1:0] exp_addr = '0;
    logic [23:0]   last_rgb;
    logic [23:0]   pm [256];
    bit            pal_ok [256];
    exp_t          sb [$];
    vec_t          tab [12];

    always #5 clk = ~clk;

    vga_scanout_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SCALE_SHIFT(SS), .ADDR_W(AW), .IDX_W(8), .COL_W(8)
    ) dut (
        .iVGA_CLK(clk), .iRST(rst), .oFB_ADDR(fb_addr), .iFB_INDEX(fb_index),
        .iPAL_WE(pal_we), .iPAL_ADDR(pal_addr), .iPAL_DATA(pal_data),
        .oHS(hs), .oVS(vs), .oBLANK_n(blank_n),
        .b_data(b), .g_data(g), .r_data(r), .oFRAME_START(frame_start)
    );

    function automatic logic [7:0] fb_fn(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [23:0] pal_val(input logic [7:0] i);
        return {i, ~i, i ^ 8'h3C};
    endfunction

    // framebuffer memory with one cycle of read latency
    always @(posedge clk) fb_index <= fb_all5 ? 8'd5 : fb_fn(fb_addr);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // one pixel clock: compare outputs of this cycle, then drive inputs and advance the model
    task automatic tick(input logic r_v, input logic we_v, input logic [7:0] wa, input logic [23:0] wd);
        exp_t          e;
        bit            act;
        logic [AW-1:0] a;
        @(negedge clk);
        last_rgb = {b, g, r};
        if (armed && sb.size() > 0) begin
            e = sb.pop_front();
            chk("hs", hs, e.hs);
            chk("vs", vs, e.vs);
            chk("blank_n", blank_n, e.act);
            chk("frame_start", frame_start, e.fs);
            if (!e.act)
                chk("rgb_blank", last_rgb, 0);
            else if (pal_ok[e.idx])
                chk("rgb", last_rgb, pm[e.idx]);
            chk("fb_addr", fb_addr, exp_addr);
            foreach (tab[i])
                if (prev_act && tab[i].v == prev_v && tab[i].h == prev_h)
                    chk("addr_tab", fb_addr, tab[i].addr);
            if (frame_start) begin
                if (win) begin
                    chk("frame_len", cnt_len, 288);
                    chk("blank_cnt", cnt_blank, 128);
                    chk("hs_low_cnt", cnt_hs, 36);
                    chk("vs_low_cnt", cnt_vs, 48);
                end
                win = 1;
                cnt_len = 0; cnt_blank = 0; cnt_hs = 0; cnt_vs = 0;
            end
            cnt_len++;
            cnt_blank += int'(blank_n);
            cnt_hs += int'(!hs);
            cnt_vs += int'(!vs);
            if (rel_pending && (frame_start || cyc - rel_cyc > 8)) begin
                chk("fs_after_rst", cyc - rel_cyc, 3);
                rel_pending = 0;
            end
        end
        if (pw_en) begin
            pm[pw_a] = pw_d;
            pal_ok[pw_a] = 1;
        end
        pw_en = we_v && !r_v;
        pw_a = wa;
        pw_d = wd;
        rst = r_v;
        pal_we = we_v;
        pal_addr = wa;
        pal_data = wd;
        if (r_v) begin
            sb.delete();
            repeat (3) sb.push_back('{hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0, idx: 8'd0});
            exp_addr = '0;
            armed = 1; win = 0; rel_pending = 0; prev_act = 0;
            m_h = 0; m_v = 0;
        end else begin
            if (last_rst) begin
                rel_cyc = cyc;
                rel_pending = 1;
            end
            act = m_h < HA && m_v < VA;
            a = AW'((m_v >> SS) * (HA >> SS) + (m_h >> SS));
            sb.push_back('{hs: !(m_h >= HA + HF && m_h < HA + HF + HS),
                           vs: !(m_v >= VA + VF && m_v < VA + VF + VS),
                           act: act, fs: m_h == 0 && m_v == 0,
                           idx: fb_all5 ? 8'd5 : fb_fn(a)});
            if (act) exp_addr = a;
            prev_h = m_h; prev_v = m_v; prev_act = act;
            m_h++;
            if (m_h == HT) begin
                m_h = 0;
                m_v = m_v == VT - 1 ? 0 : m_v + 1;
            end
        end
        last_rst = r_v;
        cyc++;
    endtask

    initial begin
        tab = '{'{0, 0, 0}, '{0, 1, 0}, '{0, 2, 1}, '{0, 3, 1}, '{0, 15, 7}, '{1, 0, 0},
                '{1, 15, 7}, '{2, 0, 8}, '{2, 9, 12}, '{3, 14, 15}, '{4, 0, 16}, '{7, 15, 31}};
        repeat (4) tick(1, 0, 0, 0);
        chk("rst_hs", hs, 1);
        chk("rst_vs", vs, 1);
        chk("rst_blank", blank_n, 0);
        chk("rst_rgb", {b, g, r}, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_fs", frame_start, 0);
        for (int i = 0; i < 256; i++) tick(0, 1, 8'(i), pal_val(8'(i)));
        repeat (620) tick(0, 0, 0, 0);
        // mid-frame reset with palette writes that must be ignored
        while (!(m_v == 5 && m_h == 7)) tick(0, 0, 0, 0);
        tick(1, 1, 8'hA5, 24'h123456);
        tick(1, 1, 8'hA5, 24'h654321);
        tick(1, 0, 0, 0);
        repeat (600) tick(0, 0, 0, 0);
        // uniform framebuffer of index 5
        tick(1, 0, 0, 0);
        fb_all5 = 1'b1;
        tick(1, 0, 0, 0);
        tick(0, 1, 8'd5, 24'h0000FF);
        while (!(m_v == 1 && m_h == 4)) tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 8'd5, 24'h00FF00);
        tick(0, 0, 0, 0);
        chk("same_cycle_old", last_rgb, 24'h0000FF);
        tick(0, 0, 0, 0);
        chk("next_pixel_new", last_rgb, 24'h00FF00);
        while (!(m_v == 2 && m_h == 16)) tick(0, 0, 0, 0);
        repeat (4) tick(0, 0, 0, 0);
        chk("blank_black", last_rgb, 0);
        repeat (400) tick(0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_scanout_ctrl.md
VGA_SCANOUT_CTRL -- requirements
Module: vga_scanout_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync lengths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync lengths in lines.
REQ-005 SHALL have parameter SCALE_SHIFT, default 0, pixel replication of 2^SCALE_SHIFT in both axes (legal values 0..2).
REQ-006 SHALL have parameters ADDR_W/IDX_W/COL_W, defaults 19/8/8: framebuffer address width, palette index width, bits per colour.
REQ-007 SHALL have ports: iVGA_CLK in 1 pixel clock; iRST in 1 reset; oFB_ADDR out ADDR_W framebuffer read address; iFB_INDEX in IDX_W framebuffer data.
REQ-008 SHALL have ports: iPAL_WE in 1 palette write enable; iPAL_ADDR in IDX_W; iPAL_DATA in 3*COL_W, {b,g,r}.
REQ-009 SHALL have ports: oHS/oVS out 1 active-low syncs; oBLANK_n out 1 active video; b_data/g_data/r_data out COL_W each; oFRAME_START out 1.
REQ-010 SHALL use one clock, iVGA_CLK; iRST SHALL be synchronous and active-high.

Function
REQ-011 SHALL keep h_cnt over 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP); v_cnt SHALL advance when h_cnt wraps and wrap at V_TOTAL-1.
REQ-012 Stage-0 active = h_cnt<H_ACTIVE AND v_cnt<V_ACTIVE; HS low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); VS analogous on v_cnt.
REQ-013 oFB_ADDR SHALL be registered (stage 1) = row_base + (h_cnt>>SCALE_SHIFT), FB_W = H_ACTIVE>>SCALE_SHIFT.
REQ-014 row_base SHALL clear at v_cnt wrap and increase by FB_W at line end only when v_cnt[SCALE_SHIFT-1:0] all ones (every line when SCALE_SHIFT=0); no multiplier.
REQ-015 oFB_ADDR SHALL hold its last value outside active video.
REQ-016 External memory has 1-cycle read latency; iFB_INDEX SHALL be consumed in stage 2 as palette read address.
REQ-017 Palette = internal 2^IDX_W x 3*COL_W synchronous RAM; stage-3 registered output drives b/g/r_data; total pixel latency 3 cycles from stage-0 counter value.
REQ-018 oHS/oVS/oBLANK_n SHALL be delayed 3 cycles to align with colour.
REQ-019 Colour outputs SHALL be 0 whenever delayed blank is inactive.
REQ-020 Palette write SHALL affect reads issued in following cycles; same-cycle read/write to one address SHALL return old data.
REQ-021 oFRAME_START SHALL pulse one cycle, coincident with first active pixel of a frame at the outputs.

Reset
REQ-022 While iRST high: counters, row_base, oFB_ADDR, colour outputs 0; oHS=oVS=1; oBLANK_n=0; oFRAME_START=0; pipeline cleared.
REQ-023 Reset mid-frame SHALL restart at h_cnt=v_cnt=0 the cycle after release; palette contents SHALL be preserved; palette writes during reset SHALL be ignored.

Configuration
REQ-024 With VGA_CURSOR_EN defined: add iCUR_X in 11 bits, iCUR_Y in 10 bits, parameters CUR_SIZE (default 8) and CUR_COLOR (default 24'hFFFFFF); cursor position sampled at v_cnt wrap.
REQ-025 With VGA_CURSOR_EN, active pixels with screen x in [iCUR_X, iCUR_X+CUR_SIZE) and y in [iCUR_Y, iCUR_Y+CUR_SIZE) SHALL output CUR_COLOR, same latency.
REQ-026 Without VGA_CURSOR_EN: cursor ports and logic absent; output is palette data only.

Verification
REQ-027 Defaults, run 2 frames -> HS period 800 clocks, low 96; VS period 420000 clocks, low 1600; oBLANK_n high 640x480 per frame.
REQ-028 SCALE_SHIFT=1, memory model -> oFB_ADDR 0,0,1,1,...,319,319 on lines 0 and 1; 320..639 on line 2; final value 76799.
REQ-029 Palette[5]=24'h0000FF, framebuffer all 5 -> r_data=8'hFF, g/b=0 exactly 3 cycles after stage-0 active; 0 during blank.
REQ-030 Write palette[5] in the same cycle index 5 is read -> that pixel old colour, next pixel new colour.
REQ-031 Assert iRST at line 200 for 3 cycles -> outputs reset values; after release h/v restart at 0; palette unchanged; oFRAME_START after 3 cycles.
REQ-032 VGA_CURSOR_EN, cursor (100,50) -> 8x8 white block at x 100..107, y 50..57; cursor moved mid-frame takes effect next frame.
